lif_spike_encoder: RTL



---
 rtl/lif_enc_pkg.sv | 24 ++
 rtl/lif_enc_channel.sv | 59 +++++
 rtl/lif_spike_encoder.sv | 101 ++++++++++
 3 files changed

// File: rtl/lif_enc_pkg.sv
// Shared types and constants for the LIF rate encoder.
// LFSR constants only matter when LIF_ENC_LFSR_EN is defined.
package lif_enc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int unsigned NUM_CH_DEF = 8;
  localparam int unsigned VAL_W_DEF  = 8;
  localparam int unsigned WIN_W_DEF  = 8;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shift Galois form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [7:0]  CH_MASK   = 8'h1D;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/lif_enc_channel.sv
// One encoder channel: intensity register, accumulate-and-carry (or LFSR
// threshold compare when LIF_ENC_LFSR_EN is defined) and the spike bit.
module lif_enc_channel
  import lif_enc_pkg::*;
#(
  parameter int VAL_W = VAL_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [VAL_W-1:0] data,
  input  logic             step,
`ifdef LIF_ENC_LFSR_EN
  input  logic [VAL_W-1:0] thresh,
`endif
  output logic             spike
);

  logic [VAL_W-1:0] val;

`ifdef LIF_ENC_LFSR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      val   <= '0;
      spike <= 1'b0;
    end else if (load) begin
      val   <= data;
      spike <= 1'b0;
    end else begin
      spike <= step && (val > thresh);
    end
  end
`else
  logic [VAL_W-1:0] acc;
  logic [VAL_W:0]   sum;

  always_comb begin
    sum = {1'b0, acc} + {1'b0, val};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val   <= '0;
      acc   <= '0;
      spike <= 1'b0;
    end else if (load) begin
      val   <= data;
      acc   <= '0;
      spike <= 1'b0;
    end else if (step) begin
      acc   <= sum[VAL_W-1:0];
      spike <= sum[VAL_W];
    end else begin
      spike <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/lif_spike_encoder.sv
// Rate encoder: per-channel intensities -> spike trains over window_len steps.
// Define LIF_ENC_LFSR_EN for stochastic LFSR encoding instead of accumulate-and-carry.
module lif_spike_encoder
  import lif_enc_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int VAL_W  = VAL_W_DEF,
  parameter int WIN_W  = WIN_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_CH*VAL_W-1:0] in_data,
  input  logic [WIN_W-1:0]        window_len,
  input  logic                    step_en,
  output logic [NUM_CH-1:0]       spikes,
  output logic                    spike_valid,
  output logic                    busy,
  output logic                    done
);

  state_t           state, state_next;
  logic [WIN_W-1:0] cnt, cnt_next, limit;
  logic             load, step, last_step;

  assign load      = (state == IDLE) && in_valid;
  assign step      = (state == RUN) && step_en;
  assign cnt_next  = cnt + WIN_W'(1);
  // Compare against the incremented count so limit 2^WIN_W-1 never wraps
  assign last_step = (cnt_next == limit);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = (window_len == '0) ? DONE : RUN;
      RUN:  if (step_en && last_step) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
    busy     = (state == RUN);
    done     = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      limit       <= '0;
      spike_valid <= 1'b0;
    end else begin
      spike_valid <= step;
      if (load) begin
        cnt   <= '0;
        limit <= window_len;
      end else if (step) begin
        cnt <= cnt_next;
      end
    end
  end

`ifdef LIF_ENC_LFSR_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst || load) lfsr <= LFSR_SEED;
    else if (step)   lfsr <= lfsr_step(lfsr);
  end
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
`ifdef LIF_ENC_LFSR_EN
    localparam logic [31:0]      MASK_FULL = i * CH_MASK;
    localparam logic [VAL_W-1:0] MASK      = MASK_FULL[VAL_W-1:0];
    logic [VAL_W-1:0] thresh;
    assign thresh = lfsr[VAL_W-1:0] ^ MASK;
`endif
    lif_enc_channel #(
      .VAL_W(VAL_W)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .data  (in_data[i*VAL_W +: VAL_W]),
      .step  (step),
`ifdef LIF_ENC_LFSR_EN
      .thresh(thresh),
`endif
      .spike (spikes[i])
    );
  end

endmodule
